// File: rtl/wb_ram_bridge.sv
// Wishbone B4 classic slave to single-port byte-enabled RAM bridge.
// Absorbs the RAM's one-cycle read latency and returns one ack/err per request.
//
// Ports:
//   clk, rst (sync, active-high)
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[31:0], wb_dat_i[31:0], wb_sel_i[3:0]
//   wb_dat_o[31:0], wb_ack_o, wb_err_o
//   ram_en_o, ram_we_o, ram_addr_o[31:0], ram_wdata_o[31:0], ram_be_o[3:0]
//   ram_rdata_i[31:0] (valid one cycle after the enable edge)
//
// Optional feature macro: WB_ERR_EN
//   defined   : requests outside the window get a one-cycle wb_err_o, no RAM access
//   undefined : no hit decode; offset wraps modulo MEM_SIZE; wb_err_o tied 0
module wb_ram_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_SIZE  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    output logic [3:0]  ram_be_o,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic [31:0] WIN_MASK = 32'(MEM_SIZE - 1);
    localparam logic [31:0] OFF_MASK = WIN_MASK & ~32'd3;

    state_t      state_q, state_d;
    logic [31:0] dat_q;
    logic [31:0] offset;
    logic        req;
    logic        acc;

    assign req    = wb_cyc_i & wb_stb_i;
    assign offset = wb_adr_i - BASE_ADDR;

`ifdef WB_ERR_EN
    logic err_q, err_d;
    logic hit;

    assign hit = offset < 32'(MEM_SIZE);
    assign acc = req & hit;
`else
    assign acc = req;
`endif

    assign wb_dat_o = dat_q;

    always_comb begin
        state_d     = state_q;
`ifdef WB_ERR_EN
        err_d       = err_q;
`endif
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = 32'd0;
        ram_wdata_o = 32'd0;
        ram_be_o    = 4'd0;
        wb_ack_o    = 1'b0;
        wb_err_o    = 1'b0;
        // Reset overrides everything: no RAM strobes, no response.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (acc) begin
                        ram_en_o    = 1'b1;
                        ram_we_o    = wb_we_i;
                        ram_be_o    = wb_sel_i;
                        ram_wdata_o = wb_dat_i;
                        ram_addr_o  = offset & OFF_MASK;
                        state_d     = wb_we_i ? RESP : RD_WAIT;
`ifdef WB_ERR_EN
                        err_d       = 1'b0;
`endif
                    end
`ifdef WB_ERR_EN
                    else if (req) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
                // Dropping cyc aborts; stb alone is not needed to finish.
                RD_WAIT: state_d = wb_cyc_i ? RESP : IDLE;
                RESP: begin
                    state_d = IDLE;
                    if (wb_cyc_i) begin
`ifdef WB_ERR_EN
                        wb_ack_o = ~err_q;
                        wb_err_o = err_q;
`else
                        wb_ack_o = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dat_q   <= 32'd0;
`ifdef WB_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef WB_ERR_EN
            err_q   <= err_d;
`endif
            // Only a read that is still live captures RAM data.
            if (state_q == RD_WAIT && wb_cyc_i) begin
                dat_q <= ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Self-checking bench for wb_ram_bridge: table of single transfers against
// a behavioural byte-enabled RAM, plus abort / stb-drop / reset sequences.
module tb_wb_ram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        ram_en_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ram_bridge #(
        .BASE_ADDR(32'h1000_0000),
        .MEM_SIZE (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (wdat),
        .wb_sel_i   (sel),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_be_o   (ram_be_o),
        .ram_rdata_i(ram_rdata)
    );

    // Behavioural RAM: 256 words, registered read, byte-enabled write.
    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) mem[ram_addr_o[9:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr_o[9:2]];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        en;
        logic [31:0] addr;
        logic        err;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input vec_t v);
        int lat;
        int exp_lat;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = v.we;
        adr = v.adr; wdat = v.dat; sel = v.sel;
        #1;
        chk("ram_en", 32'(ram_en_o), 32'(v.en));
        if (v.en) begin
            chk("ram_we", 32'(ram_we_o), 32'(v.we));
            chk("ram_addr", ram_addr_o, v.addr);
            chk("ram_be", 32'(ram_be_o), 32'(v.sel));
            if (v.we) chk("ram_wdata", ram_wdata_o, v.dat);
        end
        lat = 0;
        while (lat < 4 && !(wb_ack_o || wb_err_o)) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = (v.err || v.we) ? 1 : 2;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("ack", 32'(wb_ack_o), 32'(!v.err));
        chk("err", 32'(wb_err_o), 32'(v.err));
        chk("rdat", wb_dat_o, v.rdat);
        chk("no_accept_in_resp", 32'(ram_en_o), 32'd0);
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        ram_rdata = 32'd0;

        vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h004, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b1, 32'h004, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h1000_0006, 32'h0000_5500, 4'h2, 1'b1, 32'h004, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b1, 32'h004, 1'b0, 32'hDEAD_55EF};
        vecs[4] = '{1'b1, 32'h1000_0004, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h004, 1'b0, 32'hDEAD_55EF};
        vecs[5] = '{1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b1, 32'h004, 1'b0, 32'hDEAD_55EF};
        vecs[6] = '{1'b1, 32'h1000_03FC, 32'h1234_5678, 4'hF, 1'b1, 32'h3FC, 1'b0, 32'hDEAD_55EF};
        vecs[7] = '{1'b0, 32'h1000_03FF, 32'h0, 4'hF, 1'b1, 32'h3FC, 1'b0, 32'h1234_5678};
        vecs[8] = '{1'b1, 32'h1000_0000, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'h000, 1'b0, 32'h1234_5678};
`ifdef WB_ERR_EN
        vecs[9]  = '{1'b0, 32'h1000_0400, 32'h0, 4'hF, 1'b0, 32'h000, 1'b1, 32'h1234_5678};
        vecs[10] = '{1'b1, 32'h0FFF_FFFC, 32'h1122_3344, 4'hF, 1'b0, 32'h3FC, 1'b1, 32'h1234_5678};
        vecs[11] = '{1'b0, 32'h1000_03FC, 32'h0, 4'hF, 1'b1, 32'h3FC, 1'b0, 32'h1234_5678};
`else
        vecs[9]  = '{1'b0, 32'h1000_0400, 32'h0, 4'hF, 1'b1, 32'h000, 1'b0, 32'hA5A5_A5A5};
        vecs[10] = '{1'b1, 32'h0FFF_FFFC, 32'h1122_3344, 4'hF, 1'b1, 32'h3FC, 1'b0, 32'hA5A5_A5A5};
        vecs[11] = '{1'b0, 32'h1000_03FC, 32'h0, 4'hF, 1'b1, 32'h3FC, 1'b0, 32'h1122_3344};
`endif

        // Reset with a live request: no RAM strobes, outputs cleared.
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        adr = 32'h1000_0000; wdat = 32'hFFFF_FFFF; sel = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_ram_en", 32'(ram_en_o), 32'd0);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_err", 32'(wb_err_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;

        for (int i = 0; i < 12; i++) xfer(vecs[i]);

        // Abort: cyc dropped in RD_WAIT.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000_0004;
        @(negedge clk);
        chk("rdwait_ram_en", 32'(ram_en_o), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_ack", 32'(wb_ack_o), 32'd0);
            chk("abort_err", 32'(wb_err_o), 32'd0);
        end
        v = '{1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b1, 32'h004, 1'b0, 32'hDEAD_55EF};
        xfer(v);

        // stb dropped in RD_WAIT with cyc held: completes normally.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000_03FC;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        chk("stbdrop_ack", 32'(wb_ack_o), 32'd1);
        chk("stbdrop_dat", wb_dat_o, vecs[11].rdat);
        cyc = 1'b0;

        // Reset in RD_WAIT: no response, read data cleared.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000_0000;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ram_en", 32'(ram_en_o), 32'd0);
        @(negedge clk);
        chk("midrst_ack", 32'(wb_ack_o), 32'd0);
        chk("midrst_err", 32'(wb_err_o), 32'd0);
        chk("midrst_dat", wb_dat_o, 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("postrst_ack", 32'(wb_ack_o), 32'd0);
        v = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 1'b1, 32'h000, 1'b0, 32'hA5A5_A5A5};
        xfer(v);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
